gate_sweep_checker: RTL and testbench

// Self-checking exhaustive truth-table sweeper for N-input combinational gates.

---
 rtl/gate_sweep_checker.sv | 124 ++++++++++++
 tb/tb_gate_sweep_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper for N-input gates with mismatch counting.
// Optional first-mismatch capture port: define SWEEP_FIRST_FAIL_EN.
module gate_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             dut_out,
  output logic [WIDTH-1:0] stim,
  output logic             busy,
  output logic             check_valid,
  output logic             mismatch,
  output logic             done,
  output logic             pass,
`ifdef SWEEP_FIRST_FAIL_EN
  output logic [WIDTH-1:0] first_fail,
`endif
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_mode;
  logic [WIDTH-1:0] r_stim;
  logic [ERR_W-1:0] r_err;
  logic [CW-1:0]    r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_exp;
  logic             w_mm;
  logic             w_sat;

  assign w_accept = start && (mode <= 3'd5) &&
                    (r_state == S_IDLE || r_state == S_DONE);
  assign w_last   = &r_stim;
  assign w_sat    = &r_err;
  assign w_mm     = (r_state == S_CHECK) && (dut_out != w_exp);

  always_comb begin
    w_exp = 1'b0;
    unique case (r_mode)
      3'd0:    w_exp = &r_stim;
      3'd1:    w_exp = |r_stim;
      3'd2:    w_exp = ^r_stim;
      3'd3:    w_exp = ~&r_stim;
      3'd4:    w_exp = ~|r_stim;
      3'd5:    w_exp = ~^r_stim;
      default: w_exp = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = S_SETTLE;
      S_SETTLE:       if (r_cnt == '0) w_next = S_CHECK;
      S_CHECK:        w_next = w_last ? S_DONE : S_SETTLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= '0;
      r_stim <= '0;
      r_err  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_mode <= mode;
      r_stim <= '0;
      r_err  <= '0;
      r_cnt  <= CNT_LD;
    end else if (r_state == S_SETTLE) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end else if (r_state == S_CHECK) begin
      if (w_mm && !w_sat) r_err <= r_err + ERR_W'(1);
      if (!w_last) begin
        r_stim <= r_stim + WIDTH'(1);
        r_cnt  <= CNT_LD;
      end
    end
  end

`ifdef SWEEP_FIRST_FAIL_EN
  logic [WIDTH-1:0] r_ff;

  // A zero count at a mismatch means this is the first one of the sweep.
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_ff <= '0;
    else if (w_accept)              r_ff <= '0;
    else if (w_mm && r_err == '0)   r_ff <= r_stim;
  end

  assign first_fail = r_ff;
`endif

  assign stim        = r_stim;
  assign busy        = (r_state == S_SETTLE) || (r_state == S_CHECK);
  assign check_valid = (r_state == S_CHECK);
  assign mismatch    = w_mm;
  assign done        = (r_state == S_DONE);
  assign pass        = (r_state == S_DONE) && (r_err == '0);
  assign err_count   = r_err;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two configurations swept in parallel
// against a cycle-indexed arithmetic model of the sweep.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] mode = 3'd0;

  logic [1:0] stimA;
  logic       busyA, cvA, mmA, doneA, passA, dA;
  logic [7:0] errA;
  logic [2:0] stimB;
  logic       busyB, cvB, mmB, doneB, passB, dB;
  logic [1:0] errB;
`ifdef SWEEP_FIRST_FAIL_EN
  logic [1:0] ffA;
  logic [2:0] ffB;
`endif

  int         dgate [2];
  logic [7:0] flip  [2];
  int         cur_mode;
  int         last_err [2];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  function automatic int wof(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int sof(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int eof(input int i);
    return (i == 0) ? 8 : 2;
  endfunction

  // Gate value from the count of ones; 6 and up model an output stuck at 0.
  function automatic logic gate(input int g, input int w, input int v);
    int ones;
    ones = 0;
    for (int b = 0; b < w; b++) ones += (v >> b) & 1;
    case (g)
      0:       return ones == w;
      1:       return ones > 0;
      2:       return (ones % 2) == 1;
      3:       return ones != w;
      4:       return ones == 0;
      5:       return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic bad(input int i, input int v);
    logic g;
    g = gate(dgate[i], wof(i), v) ^ flip[i][v];
    return g != gate(cur_mode, wof(i), v);
  endfunction

  assign dA = gate(dgate[0], 2, int'(stimA)) ^ flip[0][stimA];
  assign dB = gate(dgate[1], 3, int'(stimB)) ^ flip[1][stimB];

  gate_sweep_checker #(.WIDTH(2), .SETTLE(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .dut_out(dA), .stim(stimA), .busy(busyA),
    .check_valid(cvA), .mismatch(mmA), .done(doneA), .pass(passA),
`ifdef SWEEP_FIRST_FAIL_EN
    .first_fail(ffA),
`endif
    .err_count(errA)
  );

  gate_sweep_checker #(.WIDTH(3), .SETTLE(3), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .dut_out(dB), .stim(stimB), .busy(busyB),
    .check_valid(cvB), .mismatch(mmB), .done(doneB), .pass(passB),
`ifdef SWEEP_FIRST_FAIL_EN
    .first_fail(ffB),
`endif
    .err_count(errB)
  );

  logic [2:0] ob_stim [2];
  logic [7:0] ob_err  [2];
  logic [4:0] ob_ctl  [2];
  logic [2:0] ob_ff   [2];

  assign ob_stim[0] = {1'b0, stimA};
  assign ob_stim[1] = stimB;
  assign ob_err[0]  = errA;
  assign ob_err[1]  = {6'b0, errB};
  assign ob_ctl[0]  = {busyA, doneA, cvA, mmA, passA};
  assign ob_ctl[1]  = {busyB, doneB, cvB, mmB, passB};
`ifdef SWEEP_FIRST_FAIL_EN
  assign ob_ff[0]   = {1'b0, ffA};
  assign ob_ff[1]   = ffB;
`else
  assign ob_ff[0]   = 3'd0;
  assign ob_ff[1]   = 3'd0;
`endif

  // Compare both instances at cycle k after the accepting edge.
  task automatic check_cycle(input int k);
    for (int i = 0; i < 2; i++) begin : inst
      int s, n, t, vec, cmp, cnt, ff, eerr;
      logic dn, cv, mm, ps, found;
      logic [7:0] eg, gg;
      s   = sof(i);
      n   = 1 << wof(i);
      t   = n * (s + 1);
      dn  = (k >= t);
      vec = dn ? n - 1 : k / (s + 1);
      cmp = dn ? n : k / (s + 1);
      cnt = 0; ff = 0; found = 1'b0;
      for (int v = 0; v < cmp; v++) begin
        if (bad(i, v)) begin
          cnt++;
          if (!found) begin ff = v; found = 1'b1; end
        end
      end
      eerr = (cnt > (1 << eof(i)) - 1) ? (1 << eof(i)) - 1 : cnt;
      cv   = !dn && ((k % (s + 1)) == s);
      mm   = cv && bad(i, vec);
      ps   = dn && (eerr == 0);
      if (dn) last_err[i] = eerr;
      eg = {3'(vec), !dn, dn, cv, mm, ps};
      gg = {ob_stim[i], ob_ctl[i]};
      n_vec++;
      if (gg !== eg) begin
        n_err++;
        $display("FAIL sweep_ctl inst%0d k=%0d got %b exp %b", i, k, gg, eg);
      end
      n_vec++;
      if (ob_err[i] !== 8'(eerr)) begin
        n_err++;
        $display("FAIL sweep_err inst%0d k=%0d got %0d exp %0d",
                 i, k, ob_err[i], eerr);
      end
`ifdef SWEEP_FIRST_FAIL_EN
      n_vec++;
      if (ob_ff[i] !== 3'(ff)) begin
        n_err++;
        $display("FAIL sweep_ff inst%0d k=%0d got %0d exp %0d",
                 i, k, ob_ff[i], ff);
      end
`endif
    end
  endtask

  task automatic run_sweep(input int m, input int g0, input int g1,
                           input logic [7:0] f0, input logic [7:0] f1,
                           input bit hold);
    @(negedge clk);
    dgate[0] = g0; dgate[1] = g1;
    flip[0]  = f0; flip[1]  = f1;
    cur_mode = m;
    mode     = 3'(m);
    start    = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      check_cycle(k);
      start = hold && (k < 8);
      mode  = 3'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({ob_stim[i], ob_ctl[i], ob_err[i], ob_ff[i]} !== 19'd0) begin
        n_err++;
        $display("FAIL reset inst%0d got stim=%0d ctl=%b err=%0d exp all 0",
                 i, ob_stim[i], ob_ctl[i], ob_err[i]);
      end
      last_err[i] = 0;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_bad_mode(input logic exp_done);
    @(negedge clk);
    mode  = 3'(6 + $urandom_range(0, 1));
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (ob_ctl[i][4] !== 1'b0 || ob_ctl[i][3] !== exp_done ||
            ob_err[i] !== 8'(last_err[i])) begin
          n_err++;
          $display("FAIL bad_mode inst%0d got busy=%b done=%b err=%0d exp 0 %b %0d",
                   i, ob_ctl[i][4], ob_ctl[i][3], ob_err[i], exp_done,
                   last_err[i]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_fixed;
    run_sweep(0, 0, 6, 8'h00, 8'h00, 1'b0);
    run_sweep(1, 0, 6, 8'h00, 8'h00, 1'b0);
    run_sweep(3, 3, 6, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_sweep(2, 2, 5, 8'h05, 8'h42, 1'b1);
    run_sweep(4, 4, 4, 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    dgate[0] = 1; dgate[1] = 1;
    flip[0]  = 8'h0; flip[1] = 8'h0;
    mode     = 3'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({ob_stim[i], ob_ctl[i], ob_err[i], ob_ff[i]} !== 19'd0) begin
        n_err++;
        $display("FAIL mid_reset inst%0d got stim=%0d ctl=%b err=%0d exp all 0",
                 i, ob_stim[i], ob_ctl[i], ob_err[i]);
      end
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busyA, doneA, busyB, doneB} !== 4'b0) begin
        n_err++;
        $display("FAIL mid_reset_idle c=%0d got %b exp 0000",
                 c, {busyA, doneA, busyB, doneB});
      end
    end
    run_sweep(1, 2, 1, 8'h08, 8'h81, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] f0, f1;
      f0 = (r % 3 == 0) ? 8'h00 : 8'($urandom & $urandom);
      f1 = (r % 3 == 1) ? 8'h00 : 8'($urandom & $urandom);
      run_sweep($urandom_range(0, 5), $urandom_range(0, 6),
                $urandom_range(0, 6), f0, f1, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    dgate[0] = 0; dgate[1] = 0;
    flip[0]  = 8'h0; flip[1] = 8'h0;
    cur_mode = 0;
    test_reset;
    test_bad_mode(1'b0);
    test_fixed;
    test_bad_mode(1'b1);
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
